im_loader: RTL and testbench
============================

# im_loader

Program loader that writes instruction words into the instruction memory through its write port. It accepts a byte stream over a valid/ready handshake: a 16-bit big-endian word count N, then N big-endian 16-bit instructions. Instructions are written to addresses 0..N-1. It holds the CPU in stall (`busy`) while loading, so the CPU starts fetching only from a fully loaded memory.

## Interface
- `ADDR_W`, 10, instruction memory address width (depth 2^ADDR_W = 1024)
- `DATA_W`, 16, instruction width; fixed at 2 bytes
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a load; sampled only in IDLE
- `in_valid`  in  1  byte available on `in_data`
- `in_data`  in  8  stream byte
- `in_ready`  out  1  loader accepts a byte this cycle
- `we`  out  1  instruction memory write enable, one-cycle pulse per word
- `waddr`  out  ADDR_W  write address
- `wdata`  out  DATA_W  write data
- `busy`  out  1  load in progress; CPU pc and fetch are held while high
- `done`  out  1  last load completed successfully; level signal
- `err`  out  1  last load rejected (count > 2^ADDR_W); level signal

## Operation
- States: IDLE, CNT_HI, CNT_LO, W_HI, W_LO, FIN.
- IDLE:
  - `start`=1 → CNT_HI; clear `done`/`err`; set `busy`.
  - `start` in any other state is ignored.
- CNT_HI: on byte → count[15:8], go CNT_LO.
- CNT_LO: on byte → count[7:0], then:
  - count=0 → FIN, no writes.
  - count > 2^ADDR_W → IDLE with `err`=1, `busy`=0, no writes.
  - otherwise → W_HI with word index 0.
- W_HI: on byte → hold register[15:8], go W_LO.
- W_LO: on byte → write {hold, byte} to address = index.
  - If index = count-1 → FIN; else index+1, go W_HI.
- FIN: one cycle; then `busy`=0, `done`=1, go IDLE.
- A byte is accepted only when `in_valid` && `in_ready` at a rising edge.
  - `in_ready` = 1 exactly in CNT_HI, CNT_LO, W_HI, W_LO; decoded from registered state.
  - `in_valid` low stalls the FSM indefinitely; no timeout.
- Index counter is ADDR_W+1 bits, so count=1024 reaches index 1023 without wrap.
- Words written so far are left in memory after a reset or an error; the loader does not clear memory.

## Timing
- Reset values:
  - state = IDLE.
  - `in_ready`, `we`, `busy`, `done`, `err` = 0.
  - `waddr` and `wdata` = 0.
- `we`, `waddr`, `wdata` are registered:
  - If the low byte is accepted at edge t, `we`=1 with valid address and data during cycle t..t+1.
  - `we` is 0 otherwise.
  - `waddr`/`wdata` hold their last value when `we`=0.
- Maximum throughput: one byte per cycle, one word per 2 cycles.
- Final write pulse occupies the FIN cycle. `busy` falls and `done` rises on the next edge, so the CPU never fetches concurrently with the last write.
- Start-to-`busy`: `busy`=1 the cycle after the `start` edge.
- `rst` mid-load: at the next edge, go to IDLE with all outputs at reset values and any partial word discarded.

## Structure
- Shared package `im_pkg` holds:
  - `IM_ADDR_W`=10, `IM_DATA_W`=16, `IM_DEPTH`=1024.
  - The loader state enum.
  - Reused by the instruction memory, which gains a synchronous write port (`we`, `waddr`, `wdata`) while keeping its combinational read.
- No sub-module. One FSM, a count register, an index counter and a hold byte register, all in `im_loader`.

## Test plan
- Load N=3:
  - Stream 00 03 12 34 AB CD 80 00 → `we` pulses with (0,0x1234), (1,0xABCD), (2,0x8000).
  - Then `done`=1, `busy`=0; memory reads match.
- Back-pressure: deassert `in_valid` randomly between bytes → same writes and order; `in_ready` stays high while waiting.
- N=0: stream 00 00 → no `we`; `done`=1 two cycles after the count's low byte.
- Maximum and overflow:
  - N=1024 with data = address → last write (1023, 0x03FF); `done`=1, `err`=0.
  - N=1025 (04 01) → `err`=1, `busy`=0, no `we`, `in_ready`=0 afterwards.
- `rst` after the high byte of word 1 (N=2):
  - Next cycle all outputs are 0 and state is IDLE.
  - Memory word 0 is written; word 1 is unchanged.
  - A new `start` then loads correctly.
- `start` pulses during a load are ignored; the sequence completes unchanged.

Source files
------------

// File: rtl/im_pkg.sv
// im_pkg: shared instruction-memory geometry and the program-loader state encoding.
package im_pkg;
    localparam int IM_ADDR_W = 10;
    localparam int IM_DATA_W = 16;
    localparam int IM_DEPTH  = 1 << IM_ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_W_HI,
        S_W_LO,
        S_FIN
    } ld_state_t;
endpackage

// File: rtl/im_loader.sv
// im_loader: byte-stream program loader writing big-endian 16-bit words into instruction memory.
module im_loader
    import im_pkg::*;
#(
    parameter int ADDR_W = IM_ADDR_W,
    parameter int DATA_W = IM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    ld_state_t         r_state;
    logic [15:0]       r_count;
    logic [ADDR_W:0]   r_idx;
    logic [7:0]        r_hold;
    logic              w_acc;
    logic [15:0]       w_cnt;
    logic [ADDR_W:0]   w_last;

    assign in_ready = r_state inside {S_CNT_HI, S_CNT_LO, S_W_HI, S_W_LO};
    assign w_acc    = in_valid && in_ready;
    assign w_cnt    = {r_count[15:8], in_data};
    // Count is at most 2^ADDR_W once words are streaming, so ADDR_W+1 bits hold count-1.
    assign w_last   = r_count[ADDR_W:0] - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_idx   <= '0;
            r_hold  <= '0;
            we      <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            we <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_state <= S_CNT_HI;
                    busy    <= 1'b1;
                    done    <= 1'b0;
                    err     <= 1'b0;
                end
                S_CNT_HI: if (w_acc) begin
                    r_count[15:8] <= in_data;
                    r_state       <= S_CNT_LO;
                end
                S_CNT_LO: if (w_acc) begin
                    r_count <= w_cnt;
                    r_idx   <= '0;
                    if (w_cnt == 16'd0) begin
                        r_state <= S_FIN;
                    end else if (int'(w_cnt) > (1 << ADDR_W)) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        r_state <= S_W_HI;
                    end
                end
                S_W_HI: if (w_acc) begin
                    r_hold  <= in_data;
                    r_state <= S_W_LO;
                end
                S_W_LO: if (w_acc) begin
                    we      <= 1'b1;
                    waddr   <= r_idx[ADDR_W-1:0];
                    wdata   <= {r_hold, in_data};
                    r_idx   <= r_idx + 1'b1;
                    r_state <= (r_idx == w_last) ? S_FIN : S_W_HI;
                end
                S_FIN: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: randomized self-checking bench for im_loader against a word-list reference model.
module tb_im_loader;
    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, we, busy, done, err;
    logic [9:0]  waddr;
    logic [15:0] wdata;

    int vectors = 0;
    int miscompares = 0;
    logic gaps = 1'b0;
    logic start_noise = 1'b0;

    typedef struct {
        logic [9:0]  a;
        logic [15:0] d;
    } wr_t;
    wr_t wq[$];
    logic [15:0] mem [1024];

    im_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Stand-in for the instruction memory's synchronous write port.
    always @(posedge clk) begin
        #1;
        if (we) begin
            wq.push_back('{waddr, wdata});
            mem[waddr] = wdata;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                in_valid = 1'b0;
                vectors++;
                if (in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall_ready got %b want 1", in_ready);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        if (start_noise) start = 1'($urandom_range(0, 1));
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout got in_ready=%b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if ({busy, done, err, in_ready} !== 4'b1001) begin
            miscompares++;
            $display("FAIL start_state got busy/done/err/rdy=%b want 1001", {busy, done, err, in_ready});
        end
    endtask

    task automatic run_load(input int n, input logic [15:0] words[$]);
        logic [15:0] cnt;
        bit ok;
        cnt = 16'(n);
        wq.delete();
        do_start();
        send_byte(cnt[15:8]);
        send_byte(cnt[7:0]);
        if (n <= 1024)
            foreach (words[i]) begin
                send_byte(words[i][15:8]);
                send_byte(words[i][7:0]);
            end
        @(negedge clk);
        vectors++;
        if (n > 1024) begin
            if ({busy, err, done, in_ready, we} !== 5'b01000) begin
                miscompares++;
                $display("FAIL overflow_reject got busy/err/done/rdy/we=%b want 01000", {busy, err, done, in_ready, we});
            end
        end else if ({busy, done, in_ready, we} !== {3'b100, n != 0}) begin
            miscompares++;
            $display("FAIL fin_cycle got busy/done/rdy/we=%b want %b", {busy, done, in_ready, we}, {3'b100, n != 0});
        end
        @(negedge clk);
        vectors++;
        if ({busy, done, err, we} !== {1'b0, n <= 1024, n > 1024, 1'b0}) begin
            miscompares++;
            $display("FAIL final_flags got busy/done/err/we=%b want %b", {busy, done, err, we}, {1'b0, n <= 1024, n > 1024, 1'b0});
        end
        vectors++;
        if (wq.size() != ((n <= 1024) ? n : 0)) begin
            miscompares++;
            $display("FAIL write_count got %0d want %0d", wq.size(), (n <= 1024) ? n : 0);
        end
        ok = 1;
        for (int i = 0; i < wq.size() && i < n && ok; i++) begin
            vectors++;
            if (wq[i].a !== 10'(i) || wq[i].d !== words[i] || mem[i] !== words[i]) begin
                miscompares++;
                ok = 0;
                $display("FAIL write_%0d got (%0d,%h) mem %h want (%0d,%h)", i, wq[i].a, wq[i].d, mem[i], i, words[i]);
            end
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({in_ready, we, busy, done, err, waddr, wdata} !== 31'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h want 0", {in_ready, we, busy, done, err, waddr, wdata});
        end
    endtask

    task automatic test_n3();
        logic [15:0] w[$];
        w = '{16'h1234, 16'hABCD, 16'h8000};
        run_load(3, w);
    endtask

    task automatic test_backpressure();
        logic [15:0] w[$];
        int n;
        gaps = 1'b1;
        repeat (3) begin
            n = $urandom_range(5, 40);
            w.delete();
            repeat (n) w.push_back(16'($urandom));
            run_load(n, w);
        end
        gaps = 1'b0;
    endtask

    task automatic test_zero();
        logic [15:0] w[$];
        run_load(0, w);
    endtask

    task automatic test_max();
        logic [15:0] w[$];
        for (int i = 0; i < 1024; i++) w.push_back(16'(i));
        run_load(1024, w);
        vectors++;
        if (wq.size() != 1024 || wq[1023].a !== 10'd1023 || wq[1023].d !== 16'h03FF) begin
            miscompares++;
            $display("FAIL max_last_write got size %0d want 1024 with (1023,03ff)", wq.size());
        end
    endtask

    task automatic test_overflow();
        logic [15:0] w[$];
        run_load(1025, w);
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready, we, err} !== 3'b001) begin
            miscompares++;
            $display("FAIL overflow_idle got rdy/we/err=%b want 001", {in_ready, we, err});
        end
    endtask

    task automatic test_rst_mid();
        logic [15:0] w[$];
        wq.delete();
        mem[0] = 16'h0000;
        mem[1] = 16'h5A5A;
        do_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hC3);
        send_byte(8'h3C);
        send_byte(8'h99);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({in_ready, we, busy, done, err, waddr, wdata} !== 31'd0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs got %h want 0", {in_ready, we, busy, done, err, waddr, wdata});
        end
        vectors++;
        if (mem[0] !== 16'hC33C || mem[1] !== 16'h5A5A || wq.size() != 1) begin
            miscompares++;
            $display("FAIL rst_mid_mem got %h %h n=%0d want c33c 5a5a n=1", mem[0], mem[1], wq.size());
        end
        w = '{16'h0F0F, 16'hF00D};
        run_load(2, w);
    endtask

    task automatic test_start_ignored();
        logic [15:0] w[$];
        int n;
        start_noise = 1'b1;
        gaps = 1'b1;
        n = $urandom_range(3, 20);
        repeat (n) w.push_back(16'($urandom));
        run_load(n, w);
        start_noise = 1'b0;
        gaps = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] w[$];
        int n;
        repeat (3) begin
            n = $urandom_range(1, 8);
            w.delete();
            repeat (n) w.push_back(16'($urandom));
            run_load(n, w);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_n3();
        test_backpressure();
        test_zero();
        test_max();
        test_overflow();
        test_rst_mid();
        test_start_ignored();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
